// File: rtl/gb_fanout.sv
// gb_fanout: host-bus fan-out router for NCH identical child apertures plus
// a small local CSR bank at address 0.
//
// Every read, whether it hits a child, a local register or nothing, returns
// after exactly RD+2 cycles. The host can therefore issue one read per cycle
// without tracking where each one went.
//
// Optional feature, enabled by defining GB_FANOUT_MISS_EN:
//   a 16-bit saturating miss counter, readable at local offset 2^LOCAL_AW-1.
//   Any write to that offset clears the counter.
module gb_fanout #(
    parameter int AW          = 24,
    parameter int DW          = 32,
    parameter int NCH         = 4,
    parameter int SUB_AW      = 8,
    parameter int CH_BASE_IDX = 1,
    parameter int LOCAL_AW    = 6,
    parameter int NCSR        = 4,
    parameter int RD          = 1
) (
    input  logic                gb_clk,
    input  logic                gb_rst_n,
    input  logic [AW-1:0]       gb_addr,
    input  logic [DW-1:0]       gb_wdata,
    input  logic                gb_wen,
    input  logic                gb_rstb,
    output logic [DW-1:0]       gb_rdata,
    output logic                gb_rvalid,
    output logic [SUB_AW-1:0]   ch_addr,
    output logic [DW-1:0]       ch_wdata,
    output logic [NCH-1:0]      ch_wen,
    output logic [NCH-1:0]      ch_rstb,
    input  logic [NCH*DW-1:0]   ch_rdata,
    output logic [NCSR*DW-1:0]  csr_q
);

    localparam int HW = AW - SUB_AW;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [LOCAL_AW-1:0] NCSR_L = LOCAL_AW'(NCSR);
`ifdef GB_FANOUT_MISS_EN
    localparam logic [LOCAL_AW-1:0] CNT_OFF = '1;
`endif

    // Decode results for the current host cycle
    logic [HW-1:0]        hi_addr;
    logic [LOCAL_AW-1:0]  loc_off;
    logic                 is_local;
    logic                 is_csr;
    logic                 is_cnt;
    logic                 is_child;
    logic                 is_miss;
    logic [CW-1:0]        ch_sel;
    logic [DW-1:0]        loc_rdata;
    logic                 wr_go;
    logic                 rd_go;

    // Registered state
    logic [NCSR*DW-1:0]   csr_bank_q;
    logic [NCH-1:0]       ch_wen_q;
    logic [NCH-1:0]       ch_rstb_q;
    logic [SUB_AW-1:0]    ch_addr_q;
    logic [DW-1:0]        ch_wdata_q;
    logic [DW-1:0]        gb_rdata_q;
    logic [DW-1:0]        gb_rdata_d;
    logic                 gb_rvalid_q;

    // Tag pipeline: one stage per cycle between the strobe edge and the
    // edge that registers the response. Stage RD lines up with the cycle in
    // which the addressed child drives ch_rdata.
    logic                 tag_v_q     [0:RD];
    logic                 tag_child_q [0:RD];
    logic                 tag_local_q [0:RD];
    logic [CW-1:0]        tag_idx_q   [0:RD];
    logic [DW-1:0]        tag_data_q  [0:RD];

`ifdef GB_FANOUT_MISS_EN
    logic [15:0]          miss_cnt_q;
    logic [15:0]          miss_cnt_d;
`endif

    // A simultaneous write and read executes only the write.
    assign wr_go = gb_wen;
    assign rd_go = gb_rstb && !gb_wen;

    // Address decode and local read-data selection
    always_comb begin
        hi_addr  = gb_addr[AW-1:SUB_AW];
        loc_off  = gb_addr[LOCAL_AW-1:0];
        is_local = (gb_addr[AW-1:LOCAL_AW] == '0);
        is_csr   = is_local && (loc_off < NCSR_L);
        is_cnt   = 1'b0;
`ifdef GB_FANOUT_MISS_EN
        is_cnt   = is_local && (loc_off == CNT_OFF);
`endif
        is_child = 1'b0;
        ch_sel   = '0;
        for (int n = 0; n < NCH; n++) begin
            if (hi_addr == HW'(CH_BASE_IDX + n)) begin
                is_child = 1'b1;
                ch_sel   = CW'(n);
            end
        end
        is_miss = !is_csr && !is_cnt && !is_child;

        loc_rdata = '0;
        for (int k = 0; k < NCSR; k++) begin
            if (loc_off == LOCAL_AW'(k)) begin
                loc_rdata = csr_bank_q[k*DW +: DW];
            end
        end
`ifdef GB_FANOUT_MISS_EN
        if (is_cnt) begin
            loc_rdata = {{(DW-16){1'b0}}, miss_cnt_q};
        end
`endif
    end

    // Local CSR bank, written on the strobe edge
    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            csr_bank_q <= '0;
        end else if (wr_go && is_csr) begin
            for (int k = 0; k < NCSR; k++) begin
                if (loc_off == LOCAL_AW'(k)) begin
                    csr_bank_q[k*DW +: DW] <= gb_wdata;
                end
            end
        end
    end

`ifdef GB_FANOUT_MISS_EN
    // Miss counter next state: clear first, then count, so a clear and a
    // miss landing together leave one recorded miss.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (wr_go && is_cnt) begin
            miss_cnt_d = '0;
        end
        if ((wr_go || rd_go) && is_miss && (miss_cnt_d != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_d + 16'd1;
        end
    end

    // Miss counter register
    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

    // Child-side strobes and shared address/data, one cycle after the host
    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            ch_wen_q   <= '0;
            ch_rstb_q  <= '0;
            ch_addr_q  <= '0;
            ch_wdata_q <= '0;
        end else begin
            ch_wen_q  <= '0;
            ch_rstb_q <= '0;
            if (wr_go && is_child) begin
                ch_wen_q[ch_sel] <= 1'b1;
            end
            if (rd_go && is_child) begin
                ch_rstb_q[ch_sel] <= 1'b1;
            end
            if (wr_go || rd_go) begin
                ch_addr_q <= gb_addr[SUB_AW-1:0];
            end
            if (wr_go) begin
                ch_wdata_q <= gb_wdata;
            end
        end
    end

    // Tag pipeline: captures source and local data at the strobe edge
    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            for (int i = 0; i <= RD; i++) begin
                tag_v_q[i]     <= 1'b0;
                tag_child_q[i] <= 1'b0;
                tag_local_q[i] <= 1'b0;
                tag_idx_q[i]   <= '0;
                tag_data_q[i]  <= '0;
            end
        end else begin
            tag_v_q[0]     <= rd_go;
            tag_child_q[0] <= is_child;
            tag_local_q[0] <= is_csr || is_cnt;
            tag_idx_q[0]   <= ch_sel;
            tag_data_q[0]  <= (is_csr || is_cnt) ? loc_rdata : '0;
            for (int i = 1; i <= RD; i++) begin
                tag_v_q[i]     <= tag_v_q[i-1];
                tag_child_q[i] <= tag_child_q[i-1];
                tag_local_q[i] <= tag_local_q[i-1];
                tag_idx_q[i]   <= tag_idx_q[i-1];
                tag_data_q[i]  <= tag_data_q[i-1];
            end
        end
    end

    // Response mux at the pipeline output; misses return zero
    always_comb begin
        gb_rdata_d = '0;
        if (tag_child_q[RD]) begin
            for (int n = 0; n < NCH; n++) begin
                if (tag_idx_q[RD] == CW'(n)) begin
                    gb_rdata_d = ch_rdata[n*DW +: DW];
                end
            end
        end else if (tag_local_q[RD]) begin
            gb_rdata_d = tag_data_q[RD];
        end
    end

    // Registered host response
    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            gb_rvalid_q <= 1'b0;
            gb_rdata_q  <= '0;
        end else begin
            gb_rvalid_q <= tag_v_q[RD];
            if (tag_v_q[RD]) begin
                gb_rdata_q <= gb_rdata_d;
            end
        end
    end

    assign gb_rdata  = gb_rdata_q;
    assign gb_rvalid = gb_rvalid_q;
    assign ch_addr   = ch_addr_q;
    assign ch_wdata  = ch_wdata_q;
    assign ch_wen    = ch_wen_q;
    assign ch_rstb   = ch_rstb_q;
    assign csr_q     = csr_bank_q;

endmodule

// File: tb/tb_gb_fanout.sv
// Bench for gb_fanout with default parameters. Host traffic is issued from
// one process that also updates a behavioural address-map model and queues
// the expected responses; a monitor checks responses and child strobes.
// Behaviour under GB_FANOUT_MISS_EN follows the same macro.
module tb_gb_fanout;

    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int NCH    = 4;
    localparam int SUB_AW = 8;
    localparam int NCSR   = 4;
    localparam int RD     = 1;
    localparam int LAT    = RD + 2;

    logic                gb_clk;
    logic                gb_rst_n;
    logic [AW-1:0]       gb_addr;
    logic [DW-1:0]       gb_wdata;
    logic                gb_wen;
    logic                gb_rstb;
    logic [DW-1:0]       gb_rdata;
    logic                gb_rvalid;
    logic [SUB_AW-1:0]   ch_addr;
    logic [DW-1:0]       ch_wdata;
    logic [NCH-1:0]      ch_wen;
    logic [NCH-1:0]      ch_rstb;
    logic [NCH*DW-1:0]   ch_rdata;
    logic [NCSR*DW-1:0]  csr_q;

    gb_fanout dut (
        .gb_clk    (gb_clk),
        .gb_rst_n  (gb_rst_n),
        .gb_addr   (gb_addr),
        .gb_wdata  (gb_wdata),
        .gb_wen    (gb_wen),
        .gb_rstb   (gb_rstb),
        .gb_rdata  (gb_rdata),
        .gb_rvalid (gb_rvalid),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_wen    (ch_wen),
        .ch_rstb   (ch_rstb),
        .ch_rdata  (ch_rdata),
        .csr_q     (csr_q)
    );

    initial gb_clk = 1'b0;
    always #5 gb_clk = ~gb_clk;

    int cyc = 0;
    always @(posedge gb_clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, want, cyc);
    endtask

    // Scoreboard of expected read responses and per-cycle child strobes
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t        exp_q[$];
    logic [3:0]  exp_wen   [int];
    logic [3:0]  exp_rstb  [int];
    logic [7:0]  exp_addr  [int];
    logic [31:0] exp_wdata [int];

    // Address-map model: local CSRs, miss counter and child memories
    logic [31:0] m_csr   [NCSR];
    int          m_cnt;
    logic [31:0] m_child [NCH][256];
    logic [31:0] r_child [NCH][256];

    function automatic int child_of(input logic [23:0] a);
        int h;
        h = int'(a >> 8);
        if (h >= 1 && h <= NCH) return h - 1;
        return -1;
    endfunction

    function automatic bit is_cnt_addr(input logic [23:0] a);
`ifdef GB_FANOUT_MISS_EN
        return a == 24'h00003F;
`else
        return (a == 24'h00003F) && 1'b0;
`endif
    endfunction

    task automatic issue(input bit w, input bit r, input logic [23:0] a, input logic [31:0] d);
        int          n;
        logic [31:0] rv;
        bit          miss;
        @(negedge gb_clk);
        gb_wen   = w;
        gb_rstb  = r;
        gb_addr  = a;
        gb_wdata = d;
        n    = child_of(a);
        miss = !(a < NCSR) && !is_cnt_addr(a) && (n < 0);
        if (r && !w) begin
            rv = 32'h0;
            if (a < NCSR)          rv = m_csr[int'(a)];
            else if (is_cnt_addr(a)) rv = 32'(m_cnt);
            else if (n >= 0)       rv = m_child[n][a[7:0]];
            exp_q.push_back('{rv, cyc + LAT});
            if (n >= 0) begin
                exp_rstb[cyc + 1] = 4'(1 << n);
                exp_addr[cyc + 1] = a[7:0];
            end
        end
        if (w) begin
            if (a < NCSR) m_csr[int'(a)] = d;
            else if (is_cnt_addr(a)) m_cnt = 0;
            else if (n >= 0) begin
                m_child[n][a[7:0]]  = d;
                exp_wen[cyc + 1]   = 4'(1 << n);
                exp_addr[cyc + 1]  = a[7:0];
                exp_wdata[cyc + 1] = d;
            end
        end
        if ((w || r) && miss && m_cnt < 65535) m_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge gb_clk);
            gb_wen  = 1'b0;
            gb_rstb = 1'b0;
        end
    endtask

    // Behavioural children: memories written through ch_wen, read data
    // presented RD cycles after ch_rstb; random filler otherwise.
    logic        pend_v = 1'b0;
    int          pend_n = 0;
    logic [7:0]  pend_a = '0;

    always @(negedge gb_clk) begin
        pend_v = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            if (ch_rstb[n]) begin
                pend_v = 1'b1;
                pend_n = n;
                pend_a = ch_addr;
            end
            if (ch_wen[n]) r_child[n][ch_addr] = ch_wdata;
        end
    end

    always @(posedge gb_clk) begin
        #1;
        ch_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (pend_v) ch_rdata[pend_n*DW +: DW] = r_child[pend_n][pend_a];
    end

    // Monitor: response order/latency/data and child strobes every cycle
    bit mon_en = 1'b0;
    always @(negedge gb_clk) begin
        if (mon_en) begin
            logic [3:0] ew, er;
            exp_t e;
            if (gb_rvalid) begin
                if (exp_q.size() == 0) chk("rvalid_unexpected", 32'(gb_rvalid), 32'h0);
                else begin
                    e = exp_q.pop_front();
                    chk("rdata", gb_rdata, e.data);
                    chk("rvalid_cycle", 32'(cyc), 32'(e.due));
                end
            end
            ew = exp_wen.exists(cyc)  ? exp_wen[cyc]  : 4'h0;
            er = exp_rstb.exists(cyc) ? exp_rstb[cyc] : 4'h0;
            chk("ch_wen", 32'(ch_wen), 32'(ew));
            chk("ch_rstb", 32'(ch_rstb), 32'(er));
            if (ew != 0 || er != 0) chk("ch_addr", 32'(ch_addr), 32'(exp_addr[cyc]));
            if (ew != 0) chk("ch_wdata", ch_wdata, exp_wdata[cyc]);
        end
    end

    initial begin
        logic [23:0] a;
        int          op;
        int          t0;

        for (int n = 0; n < NCH; n++)
            for (int i = 0; i < 256; i++) begin
                m_child[n][i] = $urandom;
                r_child[n][i] = m_child[n][i];
            end
        for (int k = 0; k < NCSR; k++) m_csr[k] = 32'h0;
        m_cnt    = 0;
        gb_rst_n = 1'b0;
        gb_wen   = 1'b0;
        gb_rstb  = 1'b0;
        gb_addr  = '0;
        gb_wdata = '0;
        ch_rdata = '0;

        repeat (3) @(negedge gb_clk);
        chk("reset_rvalid", 32'(gb_rvalid), 32'h0);
        chk("reset_rdata", gb_rdata, 32'h0);
        chk("reset_ch_wen", 32'(ch_wen), 32'h0);
        chk("reset_ch_rstb", 32'(ch_rstb), 32'h0);
        chk("reset_ch_addr", 32'(ch_addr), 32'h0);
        chk("reset_ch_wdata", ch_wdata, 32'h0);
        for (int k = 0; k < NCSR; k++) chk("reset_csr", csr_q[k*DW +: DW], 32'h0);
        gb_rst_n = 1'b1;
        mon_en   = 1'b1;

        // CSR round trip
        issue(1, 0, 24'h000002, 32'hDEADBEEF);
        idle(1);
        chk("csr2_after_write", csr_q[95:64], 32'hDEADBEEF);
        issue(0, 1, 24'h000002, 32'h0);
        idle(4);

        // Child read with known data
        m_child[2][5] = 32'h12345678;
        r_child[2][5] = 32'h12345678;
        issue(0, 1, 24'h000305, 32'h0);
        idle(4);

        // Back-to-back reads to child 0, CSR1, child 3
        issue(1, 0, 24'h000001, 32'hC5A11111);
        issue(0, 1, 24'h000110, 32'h0);
        issue(0, 1, 24'h000001, 32'h0);
        issue(0, 1, 24'h000420, 32'h0);
        idle(4);

        // Misses and the miss counter offset
        issue(1, 0, 24'h00003F, 32'h0);
        issue(0, 1, 24'h000500, 32'h0);
        issue(0, 1, 24'h00003F, 32'h0);
        issue(1, 0, 24'h00003F, 32'h0);
        issue(0, 1, 24'h00003F, 32'h0);
        idle(4);

        // Collision: write wins, read dropped
        issue(1, 1, 24'h000200, 32'hA5A5F00D);
        idle(4);

        // Reset while a local read is in flight; strobes during reset ignored
        issue(1, 0, 24'h000003, 32'h0BADCAFE);
        issue(0, 1, 24'h000003, 32'h0);
        t0 = cyc;
        @(negedge gb_clk);
        gb_rstb  = 1'b0;
        gb_rst_n = 1'b0;
        gb_wen   = 1'b1;
        gb_addr  = 24'h000001;
        gb_wdata = 32'hFFFFFFFF;
        exp_q.delete();
        for (int k = 0; k < NCSR; k++) m_csr[k] = 32'h0;
        m_cnt = 0;
        chk("rst_no_rvalid", 32'(gb_rvalid), 32'h0);
        for (int i = 2; i <= 5; i++) begin
            @(negedge gb_clk);
            if (cyc == t0 + 3) begin
                gb_rst_n = 1'b1;
                gb_wen   = 1'b0;
            end
            chk("rst_no_rvalid", 32'(gb_rvalid), 32'h0);
        end
        for (int k = 0; k < NCSR; k++) chk("csr_after_reset", csr_q[k*DW +: DW], 32'h0);

        // Randomised traffic
        for (int it = 0; it < 1500; it++) begin
            case ($urandom_range(0, 5))
                0:       a = 24'($urandom_range(0, NCSR - 1));
                1:       a = 24'h00003F;
                2:       a = 24'($urandom_range(4, 255));
                3, 4:    a = 24'((($urandom_range(0, NCH - 1) + 1) << 8) | $urandom_range(0, 15));
                default: a = 24'($urandom_range(24'h000500, 24'hFFFFFF));
            endcase
            op = $urandom_range(0, 9);
            if (op < 2)       idle(1);
            else if (op < 5)  issue(1, 0, a, $urandom);
            else if (op < 9)  issue(0, 1, a, 32'h0);
            else              issue(1, 1, a, $urandom);
        end
        idle(8);

        chk("drain_outstanding", 32'(exp_q.size()), 32'h0);
        for (int k = 0; k < NCSR; k++) chk("csr_final", csr_q[k*DW +: DW], m_csr[k]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gb_fanout.md
# gb_fanout

Parametrised ghostbus fan-out router with a built-in local CSR bank. It decodes one host bus into NCH identical child apertures, mirroring a generate-for array of submodule copies. Each child gets registered write and read strobes. Read data returns with a fixed, uniform latency on every path (child, local, miss), so the upstream host can pipeline reads one per cycle.

## Interface
- AW, 24, host address width
- DW, 32, data width
- NCH, 4, number of child channels
- SUB_AW, 8, address bits per child aperture (2^SUB_AW words)
- CH_BASE_IDX, 1, aperture index of child 0; child n base = (CH_BASE_IDX+n) << SUB_AW; must be ≥1
- LOCAL_AW, 6, local region size (2^LOCAL_AW words at address 0); must be ≤ SUB_AW
- NCSR, 4, number of local CSRs; must be < 2^LOCAL_AW
- RD, 1, child read latency in cycles from ch_rstb to valid ch_rdata (0 allowed)

Ports:
- gb_clk  in  1  clock, all logic on rising edge
- gb_rst_n  in  1  synchronous, active-low reset
- gb_addr  in  AW  host word address
- gb_wdata  in  DW  host write data
- gb_wen  in  1  host write strobe, single cycle
- gb_rstb  in  1  host read strobe, single cycle
- gb_rdata  out  DW  read data, valid with gb_rvalid
- gb_rvalid  out  1  one-cycle read-response pulse
- ch_addr  out  SUB_AW  shared child address, gb_addr[SUB_AW-1:0] registered
- ch_wdata  out  DW  shared child write data, registered
- ch_wen  out  NCH  per-child write strobe, one-hot or zero
- ch_rstb  out  NCH  per-child read strobe, one-hot or zero
- ch_rdata  in  NCH*DW  child n read data in slice [(n+1)*DW-1 -: DW]
- csr_q  out  NCSR*DW  CSR contents; CSR k is in slice [(k+1)*DW-1 -: DW]

## Operation
- Decode, evaluated on the strobe cycle:
  - **local**: gb_addr[AW-1:LOCAL_AW]==0.
  - **child n**: gb_addr[AW-1:SUB_AW]==CH_BASE_IDX+n, for 0≤n<NCH.
  - **miss**: everything else, including local offsets ≥NCSR (except the miss counter, see Configuration) and the gap [2^LOCAL_AW, 2^SUB_AW).
- Writes:
  - Local CSR k: loaded from gb_wdata at the strobe edge.
  - Child n: ch_wen[n] pulses for one cycle, the cycle after gb_wen, with ch_addr/ch_wdata.
  - Miss: discarded.
- Reads:
  - Child n: ch_rstb[n] pulses the cycle after gb_rstb.
  - Local read data is captured into a tag pipeline at the strobe edge.
  - Tag pipeline depth RD+1 carries {valid, source (child index / local / miss), local data}.
  - At the pipeline output, gb_rdata is registered from the tagged source:
    - child: ch_rdata slice sampled in that cycle
    - local: captured data
    - miss: 0
  - gb_rvalid=1 on the same edge.
- Unused upper bits on local reads are zero-extended; CSRs are full DW.
- gb_wen and gb_rstb in the same cycle: the write executes, the read is dropped (no ch_rstb, no gb_rvalid).
- Reads and writes may issue every cycle. Responses return strictly in issue order. No backpressure.
- Reset (gb_rst_n=0 at an edge):
  - csr_q=0, gb_rdata=0, gb_rvalid=0, ch_wen=0, ch_rstb=0, ch_addr=0, ch_wdata=0.
  - Tag pipeline cleared: in-flight reads produce no gb_rvalid.
  - Strobes presented while in reset are ignored.

## Timing
- Write: gb_wen at edge T → CSR updated at T; ch_wen/ch_addr/ch_wdata valid in cycle T+1.
- Read: gb_rstb at edge T:
  - ch_rstb high in cycle T+1.
  - Child drives ch_rdata in cycle T+1+RD.
  - gb_rvalid/gb_rdata high in cycle T+2+RD.
- Latency is RD+2 for every path (child, local, miss).
- A local read issued the cycle after a write to the same CSR returns the new value.
- gb_rvalid is never high two cycles for one read. Pipeline occupancy never exceeds RD+1 reads.

## Configuration
- GB_FANOUT_MISS_EN defined:
  - Adds a 16-bit saturating miss counter, readable at local offset 2^LOCAL_AW-1, zero-extended.
  - The counter increments once per missed read or write and holds at 0xFFFF.
  - Any write to its offset clears it. A clear and a miss in the same cycle leaves the count at 1.
  - Reset value 0.
- GB_FANOUT_MISS_EN undefined: no counter; offset 2^LOCAL_AW-1 is an ordinary miss.
- Read data and latency are unchanged in both cases.

## Test plan
All scenarios use default parameters (RD=1, so read latency is 3).
- **CSR round trip**: write addr 0x000002 data 0xDEADBEEF → csr_q[95:64]=0xDEADBEEF. Read 0x000002 at T → gb_rvalid at T+3 with 0xDEADBEEF.
- **Child read**: read 0x000305 at T → ch_rstb=4'b0100 and ch_addr=0x05 at T+1. Drive slice 2 of ch_rdata = 0x12345678 at T+2 → gb_rdata=0x12345678 with gb_rvalid at T+3.
- **Back-to-back reads**: reads to 0x000110, 0x000001, 0x000420 on consecutive cycles → three consecutive gb_rvalid pulses carrying child 0, CSR1 and child 3 data, in that order.
- **Miss**: read 0x000500 → gb_rdata=0 with gb_rvalid at T+3, and no ch strobe. With GB_FANOUT_MISS_EN, a read of 0x00003F then returns 1; a write to 0x00003F clears it to 0.
- **Collision**: gb_wen and gb_rstb together on 0x000200 → ch_wen=4'b0010 and ch_rstb=0 at T+1; no gb_rvalid.
- **Reset mid-read**: read 0x000003 at T, drive gb_rst_n=0 at T+1 → no gb_rvalid through T+5; csr_q=0.
